// File: rtl/logical_responder.sv
// Two-stage valid/ready responder for the N-bit logical-compare operation.
// S1 captures the request and its sequence tag; S2 holds the result that drives rsp_*.
module logical_responder #(
  parameter int N     = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_c,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  // Returns {c, err}; opcode 7 is the only illegal encoding.
  function automatic logic [1:0] eval_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] op);
    logic       ra;
    logic       rb;
    logic [1:0] res;
    ra  = |a;
    rb  = |b;
    res = 2'b00;
    case (op)
      3'd0:    res = {ra & rb, 1'b0};
      3'd1:    res = {ra | rb, 1'b0};
      3'd2:    res = {ra ^ rb, 1'b0};
      3'd3:    res = {(a == b), 1'b0};
      3'd4:    res = {(a != b), 1'b0};
      3'd5:    res = {(a < b), 1'b0};
      3'd6:    res = {~ra, 1'b0};
      3'd7:    res = 2'b01;
      default: res = 2'b01;
    endcase
    return res;
  endfunction

  logic             s1_v_r;
  logic [N-1:0]     s1_a_r;
  logic [N-1:0]     s1_b_r;
  logic [2:0]       s1_op_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic             s2_v_r;
  logic             s2_c_r;
  logic             s2_err_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic [TAG_W-1:0] tag_cnt_r;

  logic             ready_s2_s;
  logic             ready_s1_s;
  logic             accept_s;
  logic [1:0]       eval_s;

  // Backward ready chain and S1 result evaluation.
  always_comb begin
    ready_s2_s = !s2_v_r || rsp_ready;
    ready_s1_s = !s1_v_r || ready_s2_s;
    req_ready  = ready_s1_s && !rst;
    accept_s   = req_valid && req_ready;
    eval_s     = eval_op(s1_a_r, s1_b_r, s1_op_r);
  end

  // Pipeline stages and tag counter; S2 data is zeroed whenever the stage empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r    <= 1'b0;
      s2_v_r    <= 1'b0;
      s2_c_r    <= 1'b0;
      s2_err_r  <= 1'b0;
      s2_tag_r  <= {TAG_W{1'b0}};
      tag_cnt_r <= {TAG_W{1'b0}};
    end else begin
      if (accept_s) begin
        tag_cnt_r <= tag_cnt_r + TAG_W'(1);
      end else begin
        tag_cnt_r <= tag_cnt_r;
      end
      if (ready_s2_s) begin
        s2_v_r <= s1_v_r;
        if (s1_v_r) begin
          s2_c_r   <= eval_s[1];
          s2_err_r <= eval_s[0];
          s2_tag_r <= s1_tag_r;
        end else begin
          s2_c_r   <= 1'b0;
          s2_err_r <= 1'b0;
          s2_tag_r <= {TAG_W{1'b0}};
        end
      end else begin
        s2_v_r <= s2_v_r;
      end
      if (ready_s1_s) begin
        s1_v_r <= req_valid;
        if (req_valid) begin
          s1_a_r   <= req_a;
          s1_b_r   <= req_b;
          s1_op_r  <= req_op;
          s1_tag_r <= tag_cnt_r;
        end else begin
          s1_tag_r <= s1_tag_r;
        end
      end else begin
        s1_v_r <= s1_v_r;
      end
    end
  end

  assign rsp_valid = s2_v_r;
  assign rsp_c     = s2_c_r;
  assign rsp_err   = s2_err_r;
  assign rsp_tag   = s2_tag_r;
  assign busy      = s1_v_r || s2_v_r;

endmodule

// File: tb/tb_logical_responder.sv
// Directed bench for logical_responder: hand-computed results checked against a
// response scoreboard, plus latency, backpressure, wrap and reset scenarios.
module tb_logical_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_c;
  logic        rsp_err;
  logic [7:0]  rsp_tag;
  logic        busy;

  logical_responder #(.N(32), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       c;
    logic       err;
    logic [7:0] tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] tag_model = 8'd0;
  int         rsp_count = 0;
  int         cycle = 0;
  int         log_cyc[0:299];
  logic [7:0] log_tag[0:299];
  logic       prev_stall = 1'b0;
  logic       p_c;
  logic       p_err;
  logic [7:0] p_tag;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Response monitor: scoreboard on every handshake, stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(rsp_valid), 64'd1);
        check("stall_c", 64'(rsp_c), 64'(p_c));
        check("stall_err", 64'(rsp_err), 64'(p_err));
        check("stall_tag", 64'(rsp_tag), 64'(p_tag));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_c", 64'(rsp_c), 64'(mon_e.c));
          check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
          check("rsp_tag", 64'(rsp_tag), 64'(mon_e.tag));
        end
        if (rsp_count < 300) begin
          log_cyc[rsp_count] = cycle;
          log_tag[rsp_count] = rsp_tag;
        end
        rsp_count++;
      end
      prev_stall = rsp_valid && !rsp_ready;
      p_c   = rsp_c;
      p_err = rsp_err;
      p_tag = rsp_tag;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic c, input logic err, output int waits);
    logic done;
    done      = 1'b0;
    waits     = 0;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back({c, err, tag_model});
        tag_model = tag_model + 8'd1;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          check("send_timeout", 64'(waits), 64'd0);
          req_valid = 1'b0;
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    tag_model = 8'd0;
    rsp_count = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int accepted;
    int idx;
    logic [31:0] t2_a  [8] = '{32'hDEAD_BEEF, 32'd1, 32'd0, 32'd5, 32'd1, 32'd3, 32'd0, 32'h8000_0000};
    logic [31:0] t2_b  [8] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h1234, 32'd5, 32'd1, 32'h100, 32'd0, 32'd1};
    logic [2:0]  t2_op [8] = '{3'd3, 3'd5, 3'd6, 3'd4, 3'd7, 3'd0, 3'd1, 3'd2};
    logic        t2_c  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        t2_e  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t3_a  [4] = '{32'd1, 32'd5, 32'd7, 32'd9};
    logic [31:0] t3_b  [4] = '{32'd0, 32'd3, 32'd7, 32'd0};
    logic [2:0]  t3_op [4] = '{3'd2, 3'd5, 3'd3, 3'd6};
    logic        t3_c  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t6_a  [6] = '{32'd0, 32'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
    logic [31:0] t6_b  [6] = '{32'd4, 32'd3, 32'd0, 32'd2, 32'd7, 32'd0};
    logic [2:0]  t6_op [6] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd6, 3'd4};
    logic        t6_c  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = 32'd0; req_b = 32'd0; req_op = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset state and two-edge latency
    rsp_ready = 1'b1;
    req_a = 32'h0000_0010; req_b = 32'h0; req_op = 3'd0; req_valid = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_c", 64'(rsp_c), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    exp_q.push_back({1'b0, 1'b0, tag_model});
    tag_model = tag_model + 8'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("lat_edge1_valid", 64'(rsp_valid), 64'd0);
    check("lat_edge1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("lat_edge2_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1;
    drain();

    // 2: back-to-back stream
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(t2_a[i], t2_b[i], t2_op[i], t2_c[i], t2_e[i], w);
      check("t2_no_wait", 64'(w), 64'd0);
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t2_count", 64'(rsp_count), 64'd8);
    check("t2_consecutive", 64'(log_cyc[7] - log_cyc[0]), 64'd7);
    check("t2_last_tag", 64'(log_tag[7]), 64'd7);

    // 3: backpressure fills two stages, then drains in order
    do_reset();
    rsp_ready = 1'b0;
    accepted = 0;
    idx = 0;
    req_a = t3_a[0]; req_b = t3_b[0]; req_op = t3_op[0]; req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back({t3_c[idx], 1'b0, tag_model});
        tag_model = tag_model + 8'd1;
        idx++;
        accepted++;
      end
      @(posedge clk);
      #1;
      req_a = t3_a[idx]; req_b = t3_b[idx]; req_op = t3_op[idx];
    end
    check("t3_accepted", 64'(accepted), 64'd2);
    @(negedge clk);
    check("t3_req_ready_low", 64'(req_ready), 64'd0);
    check("t3_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check("t3_count", 64'(rsp_count), 64'd2);

    // 4: tag wrap
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      send(32'(i), 32'd0, 3'd1, (i != 0), 1'b0, w);
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t4_count", 64'(rsp_count), 64'd257);
    check("t4_tag_256th", 64'(log_tag[255]), 64'd255);
    check("t4_tag_257th", 64'(log_tag[256]), 64'd0);

    // 5: reset with both stages full and stalled
    do_reset();
    rsp_ready = 1'b0;
    send(32'd1, 32'd1, 3'd0, 1'b1, 1'b0, w);
    send(32'd1, 32'd1, 3'd7, 1'b0, 1'b1, w);
    req_valid = 1'b0;
    @(negedge clk);
    check("t5_full_valid", 64'(rsp_valid), 64'd1);
    check("t5_full_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_ready_in_rst", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    tag_model = 8'd0;
    rsp_count = 0;
    @(negedge clk);
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_rsp_c", 64'(rsp_c), 64'd0);
    check("t5_rsp_err", 64'(rsp_err), 64'd0);
    check("t5_rsp_tag", 64'(rsp_tag), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    send(32'd1, 32'd2, 3'd4, 1'b1, 1'b0, w);
    req_valid = 1'b0;
    drain();
    check("t5_post_count", 64'(rsp_count), 64'd1);
    check("t5_post_tag", 64'(log_tag[0]), 64'd0);

    // 6: full pipeline, simultaneous drain and accept
    do_reset();
    rsp_ready = 1'b0;
    send(t6_a[0], t6_b[0], t6_op[0], t6_c[0], 1'b0, w);
    send(t6_a[1], t6_b[1], t6_op[1], t6_c[1], 1'b0, w);
    rsp_ready = 1'b1;
    for (int i = 2; i < 6; i++) begin
      send(t6_a[i], t6_b[i], t6_op[i], t6_c[i], 1'b0, w);
      check("t6_no_wait", 64'(w), 64'd0);
    end
    check("t6_flow", 64'(rsp_count), 64'd4);
    req_valid = 1'b0;
    drain();
    check("t6_count", 64'(rsp_count), 64'd6);
    check("t6_last_tag", 64'(log_tag[5]), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
